mac_accum_8bit: RTL and testbench
=================================

# mac_accum_8bit

Multiply-accumulate sequencer for the 8-bit ALU datapath.
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and drives them into the combinational 8×8 array multiplier.
- Sums the 16-bit products into a wide accumulator and presents the final sum over an output valid/ready handshake.
- Sits directly around the multiplier: upstream, it feeds the multiplier's operands and enable; downstream, it consumes the multiplier's product.

## Interface
- ACC_W, 24, accumulator and result width in bits; legal range 16..32.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse that clears the accumulator and opens a new accumulation.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- in_last  input  1  qualifies the final beat of an accumulation.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- mul_a  output  8  operand to the multiplier's a input.
- mul_b  output  8  operand to the multiplier's b input.
- mul_en  output  1  drives the multiplier's enable_mul.
- product  input  16  product returned by the multiplier, same cycle.
- out_valid  output  1  result, count and flag are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  ACC_W  accumulated sum.
- count  output  8  number of beats accumulated; saturates at 255.
- flag  output  1  sticky overflow or saturation indicator (see Configuration).

## Operation
- **FSM states:** IDLE, ACCUM, DONE.
- **IDLE:**
  - in_ready=0, out_valid=0.
  - start=1 → accumulator=0, count=0, flag=0, next state ACCUM.
- **ACCUM:**
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready.
  - On an accepted beat: accumulator += zero-extended product; count += 1, saturating at 255.
  - An accepted beat with in_last=1 → next state DONE.
- **start in ACCUM:**
  - Restarts the accumulation: accumulator, count and flag are cleared; the state stays ACCUM.
  - start has priority over a simultaneous beat; that beat is dropped.
- **DONE:**
  - in_ready=0, out_valid=1.
  - result, count and flag are held stable.
  - out_valid&&out_ready → next state IDLE.
  - start is ignored in DONE.
- **Multiplier connection:**
  - mul_a=a and mul_b=b, combinational pass-through.
  - mul_en = in_valid && in_ready.
  - product is sampled only on accepted beats.
- **Arithmetic:**
  - Unsigned throughout.
  - The sum is computed at ACC_W+1 bits; bit ACC_W is the carry-out that feeds the flag logic.
- **Zero-beat accumulation:** does not exist. DONE is reachable only through an in_last beat.

## Timing
- **Reset:** on a clk edge with rst_n=0:
  - state=IDLE.
  - result=0, count=0, flag=0, out_valid=0.
  - in_ready=0 and mul_en=0.
- **Reset mid-operation:** any in-flight sum is discarded; no out_valid is produced.
- **Start to first beat:** start sampled at edge N → in_ready=1 from cycle N+1.
- **Beat throughput:** one beat per cycle; there are no bubbles while in_valid stays high.
- **Result latency:** last beat accepted at edge N → out_valid=1 in cycle N+1.
  - out_valid is registered.
  - result already includes the last beat's product.
- **Output handshake:** out_valid falls on the edge after out_valid&&out_ready. The earliest next start is then sampled in IDLE.
- **Backpressure:** out_ready low holds out_valid and all outputs indefinitely.
- **Input pass-through:** combinational from a/b/in_valid to mul_a/mul_b/mul_en. The product → accumulator path is one cycle.

## Configuration
- **MAC_SAT_EN defined:**
  - If an add carries out, the accumulator clamps to 2^ACC_W−1.
  - It stays clamped for the rest of the accumulation.
  - flag is set and sticky until the next start.
- **MAC_SAT_EN undefined:**
  - The accumulator wraps modulo 2^ACC_W.
  - flag is set on any carry-out, sticky until the next start.

## Test plan
- **Basic sum:** ACC_W=24; start, then beats 3×5, 10×10, 255×255 (in_last on the third) → result=0x00FE74 (65140), count=3, flag=0, out_valid exactly one cycle after the third beat.
- **Overflow:** ACC_W=16; beats 255×255, 255×255(last).
  - With MAC_SAT_EN → result=0xFFFF, flag=1.
  - Without MAC_SAT_EN → result=0xFC02, flag=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid rises → result, count and flag stay constant; the block returns to IDLE one edge after out_ready=1.
- **Restart:** two beats of 7×7, then start together with in_valid, then one beat 2×3(last) → result=6, count=1; the beat coinciding with start is dropped.
- **Reset mid-operation:** rst_n=0 for one cycle mid-ACCUM → all outputs 0 and in_ready=0 next cycle. Then a new start with one beat 1×1(last) → result=1.
- **Idle gating:** in_valid=1 while in IDLE or DONE → mul_en=0 and in_ready=0; the accumulator is unchanged.

Source files
------------

// File: rtl/mac_accum_8bit.sv
// mac_accum_8bit: valid/ready MAC sequencer around an external 8x8 multiplier.
// Define MAC_SAT_EN to make the accumulator saturate instead of wrap.
module mac_accum_8bit #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic             mul_en,
  input  logic [15:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic [7:0]       count,
  output logic             flag
);
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0] count_q, count_d;
  logic flag_q, flag_d;
  logic beat, clear, carry;
  logic [ACC_W:0] sum;
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = ACCUM;
    else if (state_q == ACCUM && !start && beat && in_last) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_comb begin
    in_ready  = state_q == ACCUM;
    out_valid = state_q == DONE;
    mul_a     = a;
    mul_b     = b;
    mul_en    = in_valid && in_ready;
    result    = acc_q;
    count     = count_q;
    flag      = flag_q;
  end
  // start is ignored in DONE so the presented result stays stable
  always_comb begin
    beat    = in_valid && in_ready;
    clear   = start && state_q != DONE;
    sum     = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, product};
    carry   = sum[ACC_W];
    acc_d   = clear ? '0 : beat ? ((SAT && carry) ? '1 : sum[ACC_W-1:0]) : acc_q;
    count_d = clear ? 8'd0 : beat ? count_q + 8'(count_q != 8'hFF) : count_q;
    flag_d  = clear ? 1'b0 : flag_q | (beat & carry);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end
endmodule

// File: tb/tb_mac_accum_8bit.sv
// tb_mac_accum_8bit: scoreboard bench for mac_accum_8bit with a sum-of-products reference model.
module tb_mac_accum_8bit;
  localparam int ACC_W = 24;
  localparam longint LIM = 64'sd1 <<< ACC_W;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [7:0] mul_a, mul_b, count;
  logic mul_en, in_ready, out_valid, flag;
  logic [15:0] product;
  logic [ACC_W-1:0] result;

  mac_accum_8bit #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .product(product), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .count(count), .flag(flag)
  );

  assign product = mul_en ? 16'(mul_a) * 16'(mul_b) : 16'h0;
  always #5 clk = ~clk;

  typedef struct {longint r; int c; bit f;} exp_t;
  exp_t q[$];
  int npass = 0, ntot = 0;
  int phase = 0;
  longint msum = 0;
  int mbeats = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_expected();
    exp_t e;
    e.f = msum >= LIM;
    e.r = e.f ? (SAT ? LIM - 1 : msum % LIM) : msum;
    e.c = mbeats > 255 ? 255 : mbeats;
    q.push_back(e);
  endtask

  // one clock cycle of stimulus; the model tracks which phase the block should be in
  task automatic cyc(input bit rn, input bit st, input bit v, input bit last,
                     input logic [7:0] aa, input logic [7:0] bb, input bit ord);
    rst_n = rn; start = st; in_valid = v; in_last = last; a = aa; b = bb; out_ready = ord;
    #1;
    chk("in_ready", 64'(in_ready), 64'(phase == 1));
    chk("mul_en", 64'(mul_en), 64'(v && phase == 1));
    chk("out_valid", 64'(out_valid), 64'(phase == 2));
    chk("mul_ab", 64'({mul_a, mul_b}), 64'({aa, bb}));
    if (!rn) begin
      phase = 0; msum = 0; mbeats = 0; q.delete();
    end else if (phase == 0) begin
      if (st) begin phase = 1; msum = 0; mbeats = 0; end
    end else if (phase == 1) begin
      if (st) begin
        msum = 0; mbeats = 0;
      end else if (v) begin
        msum += longint'(aa) * longint'(bb);
        mbeats++;
        if (last) begin push_expected(); phase = 2; end
      end
    end else if (ord) phase = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] aa, input logic [7:0] bb, input bit last);
    cyc(1, 0, 1, last, aa, bb, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_out: out_valid high with result %0h and nothing expected", result);
      end else begin
        chk("result", 64'(result), 64'(q[0].r));
        chk("count", 64'(count), 64'(q[0].c));
        chk("flag", 64'(flag), 64'(q[0].f));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc(0, 0, 1, 0, 8'd4, 8'd4, 1);
    chk("rst_result", 64'(result), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_flag", 64'(flag), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    repeat (3) cyc(1, 0, 1, 0, 8'd9, 8'd9, 1);
    chk("idle_acc", 64'(result), 0);
    // basic sum with backpressure
    cyc(1, 1, 0, 0, 0, 0, 1);
    beat(3, 5, 0);
    beat(10, 10, 0);
    beat(255, 255, 1);
    chk("basic_latency", 64'(out_valid), 1);
    chk("basic_result", 64'(result), 64'h00FE74);
    chk("basic_count", 64'(count), 3);
    chk("basic_flag", 64'(flag), 0);
    repeat (5) cyc(1, 1, 1, 0, 8'd1, 8'd1, 0);
    chk("bp_result", 64'(result), 64'h00FE74);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("bp_release", 64'(out_valid), 0);
    // restart drops the coincident beat
    cyc(1, 1, 0, 0, 0, 0, 1);
    beat(7, 7, 0);
    beat(7, 7, 0);
    cyc(1, 1, 1, 0, 8'd9, 8'd9, 1);
    beat(2, 3, 1);
    chk("restart_result", 64'(result), 6);
    chk("restart_count", 64'(count), 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    // reset mid-accumulation
    cyc(1, 1, 0, 0, 0, 0, 1);
    beat(5, 5, 0);
    beat(6, 6, 0);
    cyc(0, 0, 1, 0, 8'd6, 8'd6, 1);
    chk("midrst_result", 64'(result), 0);
    chk("midrst_count", 64'(count), 0);
    chk("midrst_flag", 64'(flag), 0);
    chk("midrst_in_ready", 64'(in_ready), 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    beat(1, 1, 1);
    chk("midrst_new_result", 64'(result), 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    // long accumulation: carry-out and count saturation
    cyc(1, 1, 0, 0, 0, 0, 1);
    repeat (300) beat(255, 255, 0);
    beat(255, 255, 1);
    chk("ovf_result", 64'(result), SAT ? 64'hFFFFFF : 64'd2795309);
    chk("ovf_count", 64'(count), 255);
    chk("ovf_flag", 64'(flag), 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    // randomized accumulations with gaps, restarts and backpressure
    for (int n = 0; n < 150; n++) begin
      int k;
      cyc(1, 1, 1'($urandom), 0, 8'($urandom), 8'($urandom), 1);
      k = $urandom_range(1, 12);
      for (int i = 0; i < k; i++) begin
        while ($urandom_range(0, 3) == 0) cyc(1, 0, 0, 1'($urandom), 8'($urandom), 8'($urandom), 1);
        if ($urandom_range(0, 19) == 0) cyc(1, 1, 1, 1'($urandom), 8'($urandom), 8'($urandom), 1);
        beat(8'($urandom), 8'($urandom), i == k - 1);
      end
      repeat ($urandom_range(0, 3)) cyc(1, 1'($urandom), 1, 0, 8'($urandom), 8'($urandom), 0);
      cyc(1, 0, 1'($urandom), 0, 8'($urandom), 8'($urandom), 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
